// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operand sequencer: opcode values,
// instruction field layout and FSM state encoding.
package ula_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_EQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_NE  = 3'b111;

  // Instruction is {opcode, rd, rs1, rs2}; register fields occupy AW-wide slots.
  localparam int RS2_SLOT = 0;
  localparam int RS1_SLOT = 1;
  localparam int RD_SLOT  = 2;
  localparam int OP_SLOT  = 3;

  function automatic int field_lsb(input int slot, input int aw);
    return slot * aw;
  endfunction

  function automatic int instr_width(input int aw);
    return OP_W + 3 * aw;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/ula_regfile.sv
// NREG x WIDTH register file: two combinational operand reads, one
// combinational debug read, one synchronous write port.
module ula_regfile #(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] mem [NREG];

  // NOTE: this is a small flop array, not a RAM macro, so clearing it on
  // reset is cheap and gives software a known register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns old data.
  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/ula_seq.sv
// Operand sequencer for the 8-bit ULA: accepts register loads and
// register-addressed instructions, drives the ULA and writes results back.
module ula_seq
  import ula_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NREG    = 4,
  parameter  int ALU_LAT = 1,
  localparam int AW      = $clog2(NREG),
  localparam int IW      = instr_width(AW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [IW-1:0]    instr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [AW-1:0]    res_rd,
  output logic             res_zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int CW = 2;

  if (ALU_LAT < 0 || ALU_LAT > 3) begin : g_bad_lat
    $error("ula_seq: ALU_LAT must be in 0..3");
  end
  if (NREG < 2 || (1 << AW) != NREG) begin : g_bad_nreg
    $error("ula_seq: NREG must be a power of two >= 2");
  end

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rd_q;
  logic             ld_fire;
  logic             instr_fire;
  logic             wb_now;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;

  logic [OP_W-1:0] f_op;
  logic [AW-1:0]   f_rd;
  logic [AW-1:0]   f_rs1;
  logic [AW-1:0]   f_rs2;

  assign f_op  = instr[field_lsb(OP_SLOT,  AW) +: OP_W];
  assign f_rd  = instr[field_lsb(RD_SLOT,  AW) +: AW];
  assign f_rs1 = instr[field_lsb(RS1_SLOT, AW) +: AW];
  assign f_rs2 = instr[field_lsb(RS2_SLOT, AW) +: AW];

  // NOTE: every sequential assignment uses <= so all flops sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults come first so every path assigns every signal and no
  // latch is inferred.
  always_comb begin
    state_next  = state;
    ld_ready    = 1'b0;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        ld_ready    = 1'b1;
        instr_ready = !ld_valid;
        if (instr_valid && !ld_valid) state_next = EXEC;
      end
      EXEC:    if (cnt == '0) state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ld_fire    = ld_valid && ld_ready;
  assign instr_fire = instr_valid && instr_ready;
  assign wb_now     = (state == WB);

  // Load and writeback never coincide: loads are only accepted in IDLE.
  assign rf_we    = wb_now || ld_fire;
  assign rf_waddr = wb_now ? rd_q : ld_addr;
  assign rf_wdata = wb_now ? res_data : ld_data;

  ula_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (f_rs1),
    .rdata1   (rs1_data),
    .raddr2   (f_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // res_data doubles as the captured-result register written back in WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      rd_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_fire) begin
            rd_q   <= f_rd;
            alu_op <= f_op;
            alu_a  <= rs1_data;
            alu_b  <= rs2_data;
            cnt    <= CW'(ALU_LAT);
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            res_data  <= alu_s;
            res_rd    <= rd_q;
            res_zero  <= (alu_s == '0);
            res_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
